// File: rtl/game_flow_controller.sv
// Game flow controller: credits gate, lives, respawn delay, levels, score and timed end screen.
// Optional macro HIGH_SCORE_EN builds the high-score register; otherwise high_score is tied to 0.
module game_flow_controller #(
    parameter int NUM_LIVES      = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int END_SCREEN_SEC = 15,
    parameter int CLK_HZ         = 31500000,
    parameter int SCORE_W        = 16,
    parameter int ALIEN_PTS      = 10,
    parameter int BONUS_PTS      = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_of_frame,
    input  logic               key_start_n,
    input  logic [3:0]         credits,
    input  logic               hit_player,
    input  logic               hit_alien,
    input  logic [1:0]         alien_type,
    input  logic               hit_bonus,
    input  logic               aliens_cleared,
    input  logic               aliens_landed,
    output logic               standby,
    output logic               start_game,
    output logic               game_ended,
    output logic               respawning,
    output logic               credit_consume,
    output logic               score_update,
    output logic               life_lost,
    output logic               level_up,
    output logic [3:0]         lives,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         end_time,
    output logic [SCORE_W-1:0] high_score
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_NEWGAME = 3'd2;
    localparam logic [2:0] S_PLAY    = 3'd3;
    localparam logic [2:0] S_RESPAWN = 3'd4;
    localparam logic [2:0] S_OVER    = 3'd5;

    localparam int                 TICK_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [2:0]         state;
    logic [TICK_W-1:0]  tickCnt;
    logic [7:0]         respawnCnt;
    logic [3:0]         frameFlags;
    logic [3:0]         flagsBase;
    logic [3:0]         accepted;
    logic [31:0]        pts;
    logic [SCORE_W-1:0] scoreNext;
    logic               inPlay;
    logic               wantCredit;
    logic               loadGame;
    logic               enterOver;

    function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a, input logic [31:0] b);
        logic [SCORE_W+32:0] sum;
        sum = {33'd0, a} + {{(SCORE_W+1){1'b0}}, b};
        return (sum > {33'd0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    // Event bits: 0 player, 1 alien, 2 bonus, 3 cleared. A new frame reopens every slot.
    always_comb begin
        inPlay     = (state == S_PLAY);
        flagsBase  = start_of_frame ? 4'b0000 : frameFlags;
        accepted   = inPlay ? ({aliens_cleared, hit_bonus, hit_alien, hit_player} & ~flagsBase) : 4'b0000;
        pts        = (accepted[1] ? 32'(ALIEN_PTS) * 32'(alien_type) : 32'd0) +
                     (accepted[2] ? 32'(BONUS_PTS) : 32'd0);
        scoreNext  = satAdd(score, pts);
        wantCredit = !key_start_n && (credits != 4'd0);
        loadGame   = wantCredit && ((state == S_IDLE) || ((state == S_OVER) && (end_time != 6'd0)));
        enterOver  = inPlay && (aliens_landed || (accepted[0] && (lives == 4'd1)));
    end

    always_comb begin
        standby    = (state == S_IDLE) || (state == S_START);
        start_game = (state == S_START) || (state == S_NEWGAME);
        game_ended = (state == S_OVER) || (state == S_NEWGAME);
        respawning = (state == S_RESPAWN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            frameFlags     <= 4'b0000;
            credit_consume <= 1'b0;
            score_update   <= 1'b0;
            life_lost      <= 1'b0;
            level_up       <= 1'b0;
            lives          <= 4'd0;
            level          <= 4'd0;
            score          <= '0;
            end_time       <= 6'(END_SCREEN_SEC);
            tickCnt        <= '0;
            respawnCnt     <= 8'd0;
        end else begin
            credit_consume <= 1'b0;
            life_lost      <= 1'b0;
            level_up       <= 1'b0;
            frameFlags     <= flagsBase | accepted;
            score          <= scoreNext;
            score_update   <= (scoreNext != score);

            if (accepted[3] && (level != 4'd15)) begin
                level    <= level + 4'd1;
                level_up <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (wantCredit) state <= S_START;
                end
                S_START, S_NEWGAME: begin
                    if (key_start_n) state <= S_PLAY;
                end
                S_PLAY: begin
                    if (aliens_landed) begin
                        state <= S_OVER;
                        lives <= 4'd0;
                    end else if (accepted[0]) begin
                        lives      <= lives - 4'd1;
                        life_lost  <= 1'b1;
                        respawnCnt <= 8'd0;
                        state      <= (lives == 4'd1) ? S_OVER : S_RESPAWN;
                    end
                end
                S_RESPAWN: begin
                    if (start_of_frame) begin
                        respawnCnt <= respawnCnt + 8'd1;
                        if (respawnCnt == 8'(RESPAWN_FRAMES - 1)) state <= S_PLAY;
                    end
                end
                S_OVER: begin
                    // Timeout wins over a simultaneous key press
                    if (end_time == 6'd0) state <= S_IDLE;
                    else if (wantCredit) state <= S_NEWGAME;
                    if (tickCnt == TICK_W'(CLK_HZ - 1)) begin
                        tickCnt <= '0;
                        if (end_time != 6'd0) end_time <= end_time - 6'd1;
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enterOver) begin
                end_time <= 6'(END_SCREEN_SEC);
                tickCnt  <= '0;
            end

            if (loadGame) begin
                credit_consume <= 1'b1;
                lives          <= 4'(NUM_LIVES);
                level          <= 4'd0;
                score          <= '0;
            end
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] highScoreReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            highScoreReg <= '0;
        end else if (enterOver && (scoreNext > highScoreReg)) begin
            highScoreReg <= scoreNext;
        end
    end

    assign high_score = highScoreReg;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: vector table, directed game sequences and random traffic vs a reference model.
`timescale 1ns/1ps
module tb_game_flow_controller;

    localparam int P_LIVES   = 3;
    localparam int P_RESPAWN = 60;
    localparam int P_END     = 2;
    localparam int P_CLK     = 10;
    localparam int P_SW      = 8;
    localparam int P_ALIEN   = 10;
    localparam int P_BONUS   = 100;
    localparam int SCORE_MAX = 255;
`ifdef HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_START = 1, M_NEWGAME = 2, M_PLAY = 3, M_RESPAWN = 4, M_OVER = 5;

    logic clk = 1'b0;
    logic reset, sof, keyN, hitPlayer, hitAlien, hitBonus, cleared, landed;
    logic [3:0] credits;
    logic [1:0] alienType;
    logic standby, startGame, gameEnded, respawning, creditConsume, scoreUpdate, lifeLost, levelUp;
    logic [3:0] lives, level;
    logic [P_SW-1:0] score, highScore;
    logic [5:0] endTime;

    int checks = 0;
    int failures = 0;

    // reference model state
    int mState = M_IDLE, mLives = 0, mLevel = 0, mScore = 0, mEnd = P_END, mTick = 0, mHigh = 0, mFrames = 0;
    bit mSeen[4];
    bit mCc, mSu, mLl, mLu;

    always #5 clk = ~clk;

    game_flow_controller #(
        .NUM_LIVES(P_LIVES), .RESPAWN_FRAMES(P_RESPAWN), .END_SCREEN_SEC(P_END), .CLK_HZ(P_CLK),
        .SCORE_W(P_SW), .ALIEN_PTS(P_ALIEN), .BONUS_PTS(P_BONUS)
    ) dut (
        .clk(clk), .reset(reset), .start_of_frame(sof), .key_start_n(keyN), .credits(credits),
        .hit_player(hitPlayer), .hit_alien(hitAlien), .alien_type(alienType), .hit_bonus(hitBonus),
        .aliens_cleared(cleared), .aliens_landed(landed),
        .standby(standby), .start_game(startGame), .game_ended(gameEnded), .respawning(respawning),
        .credit_consume(creditConsume), .score_update(scoreUpdate), .life_lost(lifeLost), .level_up(levelUp),
        .lives(lives), .level(level), .score(score), .end_time(endTime), .high_score(highScore)
    );

    typedef struct {
        bit rst, sof, keyN;
        logic [3:0] cr;
        bit ha;
        logic [1:0] at;
        bit hb;
        bit eStandby, eStart, eCc, eSu;
        int eLives, eScore;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mkVec(bit rst, bit s, bit k, int cr, bit ha, int at, bit hb,
                                   bit eSb, bit eSt, bit eCc, bit eSu, int eLives, int eScore);
        vec_t v;
        v.rst = rst; v.sof = s; v.keyN = k; v.cr = 4'(cr); v.ha = ha; v.at = 2'(at); v.hb = hb;
        v.eStandby = eSb; v.eStart = eSt; v.eCc = eCc; v.eSu = eSu; v.eLives = eLives; v.eScore = eScore;
        return v;
    endfunction

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelGameOver();
        mState = M_OVER;
        mEnd   = P_END;
        mTick  = 0;
        if (HS_EN && (mScore > mHigh)) mHigh = mScore;
    endtask

    task automatic modelBeginGame(int nextState);
        mState = nextState;
        mCc    = 1'b1;
        mLives = P_LIVES;
        mLevel = 0;
        mScore = 0;
    endtask

    // One clock edge of the game rules, applied to the inputs present at that edge
    task automatic modelStep();
        bit gotP, gotA, gotB, gotC;
        int pts;
        mCc = 0; mSu = 0; mLl = 0; mLu = 0;
        if (reset) begin
            mState = M_IDLE; mLives = 0; mLevel = 0; mScore = 0; mEnd = P_END; mTick = 0;
            mHigh = 0; mFrames = 0;
            for (int i = 0; i < 4; i++) mSeen[i] = 1'b0;
            return;
        end
        if (sof) for (int i = 0; i < 4; i++) mSeen[i] = 1'b0;
        gotP = (mState == M_PLAY) && hitPlayer && !mSeen[0];
        gotA = (mState == M_PLAY) && hitAlien  && !mSeen[1];
        gotB = (mState == M_PLAY) && hitBonus  && !mSeen[2];
        gotC = (mState == M_PLAY) && cleared   && !mSeen[3];
        if (gotP) mSeen[0] = 1'b1;
        if (gotA) mSeen[1] = 1'b1;
        if (gotB) mSeen[2] = 1'b1;
        if (gotC) mSeen[3] = 1'b1;

        pts = (gotA ? P_ALIEN * int'(alienType) : 0) + (gotB ? P_BONUS : 0);
        if (pts > 0 && mScore < SCORE_MAX) begin
            mScore = (mScore + pts > SCORE_MAX) ? SCORE_MAX : mScore + pts;
            mSu = 1'b1;
        end
        if (gotC && mLevel < 15) begin
            mLevel++;
            mLu = 1'b1;
        end

        case (mState)
            M_IDLE: if (!keyN && credits != 0) modelBeginGame(M_START);
            M_START, M_NEWGAME: if (keyN) mState = M_PLAY;
            M_PLAY: begin
                if (landed) begin
                    mLives = 0;
                    modelGameOver();
                end else if (gotP) begin
                    mLives--;
                    mLl = 1'b1;
                    if (mLives == 0) modelGameOver();
                    else begin
                        mState  = M_RESPAWN;
                        mFrames = 0;
                    end
                end
            end
            M_RESPAWN: if (sof) begin
                mFrames++;
                if (mFrames == P_RESPAWN) mState = M_PLAY;
            end
            M_OVER: begin
                mTick++;
                if (mEnd == 0) mState = M_IDLE;
                else if (!keyN && credits != 0) modelBeginGame(M_NEWGAME);
                if (mTick == P_CLK) begin
                    mTick = 0;
                    if (mEnd > 0) mEnd--;
                end
            end
            default: mState = M_IDLE;
        endcase
    endtask

    function automatic logic [37:0] actVec();
        return {standby, startGame, gameEnded, respawning, creditConsume, scoreUpdate, lifeLost, levelUp,
                lives, level, score, endTime, highScore};
    endfunction

    function automatic logic [37:0] expVec();
        return {(mState == M_IDLE || mState == M_START), (mState == M_START || mState == M_NEWGAME),
                (mState == M_OVER || mState == M_NEWGAME), (mState == M_RESPAWN),
                mCc, mSu, mLl, mLu, 4'(mLives), 4'(mLevel), 8'(mScore), 6'(mEnd), 8'(mHigh)};
    endfunction

    task automatic step(string name);
        @(posedge clk);
        modelStep();
        #1;
        checkVal(name, 64'(actVec()), 64'(expVec()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nPulse;
        int frames;
        reset = 1; sof = 0; keyN = 1; credits = 0; hitPlayer = 0; hitAlien = 0; alienType = 0;
        hitBonus = 0; cleared = 0; landed = 0;

        //                 rst sof key cr ha at hb | sb st cc su lives score
        tbl[0] = mkVec(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[1] = mkVec(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[2] = mkVec(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[3] = mkVec(0, 0, 0, 2, 0, 0, 0,   1, 1, 1, 0, 3, 0);
        tbl[4] = mkVec(0, 0, 0, 2, 0, 0, 0,   1, 1, 0, 0, 3, 0);
        tbl[5] = mkVec(0, 0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 3, 0);
        tbl[6] = mkVec(0, 0, 1, 2, 1, 2, 0,   0, 0, 0, 1, 3, 20);
        tbl[7] = mkVec(0, 0, 1, 2, 1, 2, 0,   0, 0, 0, 0, 3, 20);
        tbl[8] = mkVec(0, 1, 1, 2, 1, 2, 1,   0, 0, 0, 1, 3, 140);
        tbl[9] = mkVec(0, 0, 1, 2, 1, 2, 1,   0, 0, 0, 0, 3, 140);

        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst; sof = tbl[i].sof; keyN = tbl[i].keyN; credits = tbl[i].cr;
            hitAlien = tbl[i].ha; alienType = tbl[i].at; hitBonus = tbl[i].hb;
            step($sformatf("cycle_table%0d", i));
            checkVal($sformatf("table%0d", i),
                     {standby, startGame, creditConsume, scoreUpdate, lives, score},
                     {tbl[i].eStandby, tbl[i].eStart, tbl[i].eCc, tbl[i].eSu, 4'(tbl[i].eLives), 8'(tbl[i].eScore)});
        end

        // alien held for 50 cycles in one frame scores once
        hitBonus = 0; hitAlien = 1; alienType = 2; nPulse = 0;
        for (int i = 0; i < 50; i++) begin
            sof = (i == 0);
            step("cycle_alien_held");
            nPulse += int'(scoreUpdate);
        end
        checkVal("alien_held_pulses", nPulse, 1);
        checkVal("alien_held_score", score, 160);

        sof = 1; alienType = 0; step("cycle_type0");
        checkVal("type0_no_update", {scoreUpdate, score}, {1'b0, 8'd160});
        sof = 0; hitAlien = 0; step("cycle_type0_idle");

        for (int f = 0; f < 3; f++) begin
            sof = 1; hitAlien = 1; alienType = 3; step("cycle_type3");
            sof = 0; hitAlien = 0; step("cycle_gap"); step("cycle_gap");
        end
        checkVal("score_250", score, 250);

        sof = 1; hitBonus = 1; step("cycle_bonus_sat");
        checkVal("bonus_saturates", {scoreUpdate, score}, {1'b1, 8'd255});
        sof = 0; hitBonus = 0; step("cycle_gap");
        sof = 1; hitAlien = 1; alienType = 1; step("cycle_at_max");
        checkVal("at_max_no_update", {scoreUpdate, score}, {1'b0, 8'd255});
        sof = 0; hitAlien = 0; step("cycle_gap");

        nPulse = 0;
        for (int f = 0; f < 20; f++) begin
            sof = 1; cleared = 1; step("cycle_cleared"); nPulse += int'(levelUp);
            sof = 0; cleared = 0; step("cycle_gap");     nPulse += int'(levelUp);
            step("cycle_gap");                           nPulse += int'(levelUp);
        end
        checkVal("level_saturates", level, 15);
        checkVal("level_up_pulses", nPulse, 15);

        // reset in the middle of a game
        keyN = 1; credits = 0; reset = 1; step("cycle_reset_mid");
        checkVal("reset_outputs", 64'(actVec()), 64'({1'b1, 7'b0, 4'd0, 4'd0, 8'd0, 6'd2, 8'd0}));
        reset = 0;

        // game 2: score 130, lose all lives, time out
        credits = 1; keyN = 0; step("cycle_g2_start");
        keyN = 1; step("cycle_g2_play");
        sof = 1; hitAlien = 1; alienType = 3; hitBonus = 1; step("cycle_g2_score");
        checkVal("alien_plus_bonus", score, 130);
        sof = 0; hitAlien = 0; hitBonus = 0; step("cycle_gap");
        for (int h = 0; h < 3; h++) begin
            sof = 1; hitPlayer = 1; step("cycle_hit");
            checkVal($sformatf("hit%0d_lives", h), {lifeLost, lives}, {1'b1, 4'(2 - h)});
            sof = 0; hitPlayer = 0;
            if (h < 2) begin
                step("cycle_gap");
                checkVal($sformatf("hit%0d_respawning", h), respawning, 1);
                frames = 0;
                while (respawning && frames < 100) begin
                    sof = 1; step("cycle_respawn");
                    sof = 0; step("cycle_respawn"); step("cycle_respawn");
                    frames++;
                end
                checkVal($sformatf("respawn%0d_frames", h), frames, P_RESPAWN);
            end else begin
                checkVal("over_after_last_life", {gameEnded, respawning}, 2'b10);
            end
        end
        checkVal("high_after_g2", highScore, HS_EN ? 130 : 0);
        for (int i = 0; i < 10; i++) step("cycle_over");
        checkVal("end_time_1", endTime, 1);
        for (int i = 0; i < 10; i++) step("cycle_over");
        checkVal("end_time_0", endTime, 0);
        step("cycle_timeout");
        checkVal("timeout_to_idle", {standby, gameEnded}, 2'b10);

        // game 3: score 90, aliens land, new game from the end screen
        keyN = 0; step("cycle_g3_start");
        keyN = 1; step("cycle_g3_play");
        for (int f = 0; f < 3; f++) begin
            sof = 1; hitAlien = 1; alienType = 3; step("cycle_type3");
            sof = 0; hitAlien = 0; step("cycle_gap");
        end
        checkVal("score_90", score, 90);
        landed = 1; step("cycle_landed");
        checkVal("landed_over", {gameEnded, lives}, {1'b1, 4'd0});
        landed = 0;
        for (int i = 0; i < 10; i++) step("cycle_over");
        checkVal("g3_end_time_1", endTime, 1);
        keyN = 0; step("cycle_newgame");
        checkVal("newgame_entry", {gameEnded, startGame, creditConsume, score, lives},
                 {1'b1, 1'b1, 1'b1, 8'd0, 4'd3});
        checkVal("high_after_g3", highScore, HS_EN ? 130 : 0);
        keyN = 1; step("cycle_g4_play");

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 999) == 0);
            sof       = ($urandom_range(0, 3) == 0);
            keyN      = ($urandom_range(0, 2) != 0);
            credits   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            hitPlayer = ($urandom_range(0, 39) == 0);
            hitAlien  = ($urandom_range(0, 5) == 0);
            alienType = 2'($urandom_range(0, 3));
            hitBonus  = ($urandom_range(0, 19) == 0);
            cleared   = ($urandom_range(0, 29) == 0);
            landed    = ($urandom_range(0, 399) == 0);
            step("cycle_random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Parametrised successor to the current game-state controller. Owns the full game flow: credits gate, lives, respawn delay, level progression, score accumulation and the timed end screen. Sits between the pixel-level collision detectors / object blocks and the score, lives and screen-select logic of the top level. Per-frame event de-duplication is built in, so downstream blocks receive at most one pulse per event type per frame.

Parameters:
NUM_LIVES, 3, lives loaded at game start (1..15)
RESPAWN_FRAMES, 60, frames spent in RESPAWN after losing a life (1..255)
END_SCREEN_SEC, 15, end-screen countdown length in seconds (1..63)
CLK_HZ, 31500000, clock frequency used by the internal one-second tick counter
SCORE_W, 16, score width in bits
ALIEN_PTS, 10, points per alien-type unit (alien kill = ALIEN_PTS * alien_type)
BONUS_PTS, 100, points for a bonus-ship kill

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_of_frame  in  1  one-cycle pulse at start of each frame
key_start_n  in  1  start key, active low, already debounced
credits  in  4  credits available; nonzero means a game may start
hit_player  in  1  level: player hit by alien shot or alien body this pixel
hit_alien  in  1  level: player shot overlaps alien this pixel
alien_type  in  2  type of alien at the hit pixel (0..3)
hit_bonus  in  1  level: player shot overlaps bonus ship
aliens_cleared  in  1  level: alien matrix empty
aliens_landed  in  1  level: aliens reached player row
standby  out  1  1 in IDLE/START
start_game  out  1  1 in START/NEWGAME
game_ended  out  1  1 in OVER/NEWGAME
respawning  out  1  1 in RESPAWN
credit_consume  out  1  one-cycle pulse on entry to START or NEWGAME
score_update  out  1  one-cycle pulse when score changes
life_lost  out  1  one-cycle pulse on each life decrement
level_up  out  1  one-cycle pulse on level increment
lives  out  4  remaining lives
level  out  4  current level, 0-based
score  out  SCORE_W  accumulated score
end_time  out  6  seconds remaining on end screen
high_score  out  SCORE_W  best score (see Optional Feature)

Behaviour:
- Reset (sync, active-high, priority over all): state IDLE; all pulses 0; lives=0, level=0, score=0, end_time=END_SCREEN_SEC, high_score=0, tick counter=0, frame flags cleared.
- Frame flags: one flag each for player, alien, bonus, cleared. An event is accepted only when its level input is 1 and its flag is 0, and this sets the flag. start_of_frame clears all flags. start_of_frame and an input in the same cycle: the flag is cleared and the event is accepted for the new frame.
- Events are accepted only in PLAY. In all other states they are ignored and do not set flags.
- Score, accepted events: add ALIEN_PTS*alien_type for alien and BONUS_PTS for bonus. Both in the same cycle add the sum. Registered, so score changes 1 cycle after acceptance; score_update pulses in that cycle. Saturate at 2^SCORE_W-1. alien_type=0 adds 0 and gives no score_update pulse.
- States and transitions:
  - IDLE: key_start_n=0 and credits!=0 -> START (credit_consume pulse).
  - START / NEWGAME: on entry load lives=NUM_LIVES, level=0, score=0. key_start_n=1 -> PLAY.
  - PLAY:
    - aliens_landed -> OVER, lives=0 (highest priority).
    - Accepted hit_player: lives-1 and life_lost pulse. Result 0 -> OVER, else -> RESPAWN.
    - Accepted aliens_cleared: level+1, saturating at 15; level_up pulse; stay in PLAY.
  - RESPAWN: counts start_of_frame pulses; after RESPAWN_FRAMES pulses -> PLAY.
  - OVER:
    - On entry end_time=END_SCREEN_SEC and tick counter=0.
    - Tick counter wraps at CLK_HZ-1; each wrap decrements end_time.
    - end_time==0 -> IDLE.
    - Else key_start_n=0 and credits!=0 -> NEWGAME (credit_consume pulse). Timeout has priority if both occur in the same cycle.
- Credits are not decremented here; credit_consume is the request to the credit block.

Optional Feature:
HIGH_SCORE_EN: when defined, high_score updates to score on the cycle of entry to OVER if score>high_score; it is held across games and cleared only by reset. When undefined, high_score is constant 0 and no comparator or register is built.

Test Plan:
- Reset, credits=0, key_start_n=0 -> stays IDLE, standby=1. Then credits=2 -> START, credit_consume one pulse, lives=3; release key -> PLAY.
- PLAY, hit_alien held 50 cycles with alien_type=2 in one frame -> score +20 exactly once, one score_update pulse; next frame, hit_alien with hit_bonus in the same cycle -> score +120.
- PLAY, hit_player once per frame for 3 frames (respawn wait honoured) -> lives 3->2->1->0, three life_lost pulses, RESPAWN for 60 frames between hits, OVER after third.
- OVER with CLK_HZ=10, END_SCREEN_SEC=2 -> end_time 2->1->0 every 10 cycles, then IDLE; repeat with key press at end_time=1 -> NEWGAME, score cleared.
- SCORE_W=8, score=250, bonus kill -> score=255 (saturated); aliens_cleared for 20 frames -> level saturates at 15.
- HIGH_SCORE_EN defined: game ends with 130, then 90 -> high_score 130 after both; reset mid-PLAY -> IDLE with all outputs at reset values.
